// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response bundle for the shared ALU arbiter.
// Carries both requester ports plus the shared result and busy flag.
interface alu_arbiter_if #(
  parameter int N = 15
);

  logic         req0_valid;
  logic         req0_ready;
  logic [2:0]   req0_op;
  logic [N:0]   req0_a;
  logic [N:0]   req0_b;

  logic         req1_valid;
  logic         req1_ready;
  logic [2:0]   req1_op;
  logic [N:0]   req1_a;
  logic [N:0]   req1_b;

  logic         rsp0_valid;
  logic         rsp0_ready;
  logic         rsp1_valid;
  logic         rsp1_ready;

  logic [N:0]   rsp_data;
  logic         rsp_zero;
  logic         busy;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  rsp0_valid, rsp1_valid,
    output rsp0_ready, rsp1_ready,
    input  rsp_data, rsp_zero, busy
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output rsp0_valid, rsp1_valid,
    input  rsp0_ready, rsp1_ready,
    output rsp_data, rsp_zero, busy
  );

endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one ALU between two requesters.
// Captures operands, runs 1 or MUL_CYCLES exec cycles, holds result.
module alu_arbiter #(
  parameter int N          = 15,
  parameter int MUL_CYCLES = 3
) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus
);

  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  logic          prio;
  logic          owner;
  logic [2:0]    op_q;
  logic [N:0]    a_q;
  logic [N:0]    b_q;
  logic [CW-1:0] cnt;

  logic [N:0]    data_q;
  logic          zero_q;
  logic          rv0_q;
  logic          rv1_q;
  logic          busy_q;

  logic          gnt0;
  logic          gnt1;
  logic          rdy0;
  logic          rdy1;
  logic          acc0;
  logic          acc1;
  logic          rsp_done;
  logic [2:0]    sel_op;
  logic [N:0]    sel_a;
  logic [N:0]    sel_b;
  logic [N:0]    res;

  // Round-robin grant: a lone requester always wins, a tie uses prio.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (1'b1)
      (bus.req0_valid & bus.req1_valid): begin
        gnt0 = ~prio;
        gnt1 = prio;
      end
      (bus.req0_valid & ~bus.req1_valid): gnt0 = 1'b1;
      (~bus.req0_valid & bus.req1_valid): gnt1 = 1'b1;
      default: ;
    endcase
  end

  assign rdy0 = rst & (state == IDLE) & gnt0;
  assign rdy1 = rst & (state == IDLE) & gnt1;
  assign acc0 = rdy0 & bus.req0_valid;
  assign acc1 = rdy1 & bus.req1_valid;

  assign sel_op = acc1 ? bus.req1_op : bus.req0_op;
  assign sel_a  = acc1 ? bus.req1_a  : bus.req0_a;
  assign sel_b  = acc1 ? bus.req1_b  : bus.req0_b;

  assign rsp_done = (rv0_q & bus.rsp0_ready)
                  | (rv1_q & bus.rsp1_ready);

  // ALU datapath on the captured operands; all results wrap to N+1 bits.
  always_comb begin
    res = '0;
    case (op_q)
      3'b000:  res = a_q + b_q;
      3'b001:  res = a_q - b_q;
      3'b010:  res = a_q + b_q;
      3'b011:  res = a_q + b_q;
      3'b100:  res = a_q & b_q;
      3'b101:  res = a_q | b_q;
      3'b110:  res = a_q ^ b_q;
      3'b111:  res = a_q * b_q;
      default: res = '0;
    endcase
  end

  // Control FSM with capture registers and registered response outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      prio   <= 1'b0;
      owner  <= 1'b0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      cnt    <= '0;
      data_q <= '0;
      zero_q <= 1'b0;
      rv0_q  <= 1'b0;
      rv1_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (acc0 | acc1) begin
            owner  <= acc1;
            prio   <= ~acc1;
            op_q   <= sel_op;
            a_q    <= sel_a;
            b_q    <= sel_b;
            cnt    <= (sel_op == 3'b111)
                    ? CW'(MUL_CYCLES - 1) : '0;
            busy_q <= 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            data_q <= res;
            zero_q <= (res == '0);
            rv0_q  <= ~owner;
            rv1_q  <= owner;
            state  <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_done) begin
            rv0_q  <= 1'b0;
            rv1_q  <= 1'b0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req0_ready = rdy0;
  assign bus.req1_ready = rdy1;
  assign bus.rsp0_valid = rv0_q;
  assign bus.rsp1_valid = rv1_q;
  assign bus.rsp_data   = data_q;
  assign bus.rsp_zero   = zero_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors plus a transaction-level model
// compared against the arbiter outputs on every falling edge.
module tb_alu_arbiter;

  localparam int N   = 7;
  localparam int MC  = 3;

  logic clk;
  logic rst;

  alu_arbiter_if #(.N(N)) bus ();

  alu_arbiter #(.N(N), .MUL_CYCLES(MC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  int         ecount = 0;
  bit         m_out  = 0;
  bit         m_own  = 0;
  bit         m_fav  = 0;
  int         m_due  = 0;
  logic [7:0] m_res  = '0;

  function automatic logic [7:0] golden(input logic [2:0] op,
                                        input logic [7:0] a,
                                        input logic [7:0] b);
    int x;
    x = 0;
    case (op)
      3'd0, 3'd2, 3'd3: x = int'(a) + int'(b);
      3'd1: x = int'(a) - int'(b);
      3'd4: x = int'(a & b);
      3'd5: x = int'(a | b);
      3'd6: x = int'(a ^ b);
      3'd7: x = int'(a) * int'(b);
      default: x = 0;
    endcase
    return x[7:0];
  endfunction

  function automatic bit exp_rdy(input bit p);
    bit mine, other;
    mine  = p ? bus.req1_valid : bus.req0_valid;
    other = p ? bus.req0_valid : bus.req1_valid;
    return rst && !m_out && mine && (!other || m_fav == p);
  endfunction

  function automatic bit exp_rv(input bit p);
    return m_out && (m_own == p) && (ecount >= m_due);
  endfunction

  always @(posedge clk) begin
    bit pv0, pv1, pr0, pr1;
    pv0 = exp_rv(1'b0);
    pv1 = exp_rv(1'b1);
    pr0 = exp_rdy(1'b0);
    pr1 = exp_rdy(1'b1);
    ecount = ecount + 1;
    if (!rst) begin
      m_out = 0;
      m_fav = 0;
    end else if (m_out) begin
      if ((pv0 && bus.rsp0_ready) || (pv1 && bus.rsp1_ready))
        m_out = 0;
    end else if ((pr0 && bus.req0_valid) ||
                 (pr1 && bus.req1_valid)) begin
      m_own = pr1;
      m_fav = !pr1;
      if (pr1)
        m_res = golden(bus.req1_op, bus.req1_a, bus.req1_b);
      else
        m_res = golden(bus.req0_op, bus.req0_a, bus.req0_b);
      m_due = ecount +
        (((pr1 ? bus.req1_op : bus.req0_op) == 3'd7) ? MC : 1);
      m_out = 1;
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    check("never_both_ready",
          {31'd0, bus.req0_ready & bus.req1_ready}, 32'd0);
    check("req0_ready", {31'd0, bus.req0_ready},
          {31'd0, exp_rdy(1'b0)});
    check("req1_ready", {31'd0, bus.req1_ready},
          {31'd0, exp_rdy(1'b1)});
    check("rsp0_valid", {31'd0, bus.rsp0_valid},
          {31'd0, exp_rv(1'b0)});
    check("rsp1_valid", {31'd0, bus.rsp1_valid},
          {31'd0, exp_rv(1'b1)});
    check("busy", {31'd0, bus.busy}, {31'd0, m_out});
    if (exp_rv(1'b0) || exp_rv(1'b1)) begin
      check("rsp_data", {24'd0, bus.rsp_data}, {24'd0, m_res});
      check("rsp_zero", {31'd0, bus.rsp_zero},
            {31'd0, m_res == 8'd0});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input bit p, input logic [2:0] op,
                       input logic [7:0] a, input logic [7:0] b,
                       output int acc);
    step();
    if (p) begin
      bus.req1_valid = 1; bus.req1_op = op;
      bus.req1_a = a;     bus.req1_b = b;
    end else begin
      bus.req0_valid = 1; bus.req0_op = op;
      bus.req0_a = a;     bus.req0_b = b;
    end
    acc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (p ? bus.req1_ready : bus.req0_ready) begin
        acc = ecount + 1;
        step();
        if (p) bus.req1_valid = 0;
        else   bus.req0_valid = 0;
        break;
      end
    end
    if (acc < 0) check("accept_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_rsp(input bit p, input int acc,
                          output int lat);
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (p ? bus.rsp1_valid : bus.rsp0_valid) begin
        lat = ecount - acc;
        break;
      end
    end
    if (lat < 0) check("rsp_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int acc, lat, cnt;
    logic [7:0] held;
    bit grants[$];

    rst = 0;
    bus.req0_valid = 1; bus.req0_op = 3'd4;
    bus.req0_a = 8'hF0; bus.req0_b = 8'h3C;
    bus.req1_valid = 1; bus.req1_op = 3'd5;
    bus.req1_a = 8'h0F; bus.req1_b = 8'h30;
    bus.rsp0_ready = 1; bus.rsp1_ready = 1;

    // reset state, both requesters asserting valid
    step();
    step();
    @(negedge clk);
    check("rst_ready0", {31'd0, bus.req0_ready}, 32'd0);
    check("rst_ready1", {31'd0, bus.req1_ready}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_rv0", {31'd0, bus.rsp0_valid}, 32'd0);
    check("rst_rv1", {31'd0, bus.rsp1_valid}, 32'd0);
    check("rst_data", {24'd0, bus.rsp_data}, 32'd0);
    check("rst_zero", {31'd0, bus.rsp_zero}, 32'd0);

    // contention: grants alternate starting at port 0
    step();
    rst = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.req0_ready) grants.push_back(1'b0);
      if (bus.req1_ready) grants.push_back(1'b1);
      if (bus.rsp0_valid)
        check("and_result", {24'd0, bus.rsp_data}, 32'h30);
      if (bus.rsp1_valid)
        check("or_result", {24'd0, bus.rsp_data}, 32'h3F);
      step();
    end
    bus.req0_valid = 0;
    bus.req1_valid = 0;
    check("grant_count", grants.size(), 32'd4);
    for (int i = 0; i < 4 && i < grants.size(); i++)
      check("grant_order", {31'd0, grants[i]}, i % 2);

    // add with carry into the MSB
    issue(1'b0, 3'd0, 8'h7F, 8'h01, acc);
    wait_rsp(1'b0, acc, lat);
    check("add_lat", lat, 32'd1);
    check("add_data", {24'd0, bus.rsp_data}, 32'h80);
    check("add_zero", {31'd0, bus.rsp_zero}, 32'd0);
    check("add_rv1", {31'd0, bus.rsp1_valid}, 32'd0);

    // subtract to zero on port 1
    issue(1'b1, 3'd1, 8'h05, 8'h05, acc);
    wait_rsp(1'b1, acc, lat);
    check("sub_data", {24'd0, bus.rsp_data}, 32'h00);
    check("sub_zero", {31'd0, bus.rsp_zero}, 32'd1);
    check("sub_rv0", {31'd0, bus.rsp0_valid}, 32'd0);

    // add wraps to zero
    issue(1'b0, 3'd0, 8'hFF, 8'h01, acc);
    wait_rsp(1'b0, acc, lat);
    check("wrap_data", {24'd0, bus.rsp_data}, 32'h00);
    check("wrap_zero", {31'd0, bus.rsp_zero}, 32'd1);

    // multiply, operands disturbed after accept
    issue(1'b0, 3'd7, 8'h10, 8'h11, acc);
    bus.req0_a = 8'hFF;
    bus.req0_b = 8'hFF;
    wait_rsp(1'b0, acc, lat);
    check("mul_lat", lat, MC);
    check("mul_data", {24'd0, bus.rsp_data}, 32'h10);

    // backpressure on port 0 while port 1 waits
    step();
    bus.rsp0_ready = 0;
    issue(1'b0, 3'd6, 8'hAA, 8'h55, acc);
    bus.req1_valid = 1; bus.req1_op = 3'd0;
    bus.req1_a = 8'h01; bus.req1_b = 8'h02;
    wait_rsp(1'b0, acc, lat);
    held = bus.rsp_data;
    check("xor_data", {24'd0, held}, 32'hFF);
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      check("bp_valid", {31'd0, bus.rsp0_valid}, 32'd1);
      check("bp_data", {24'd0, bus.rsp_data}, {24'd0, held});
      check("bp_zero", {31'd0, bus.rsp_zero}, 32'd0);
      check("bp_ready1", {31'd0, bus.req1_ready}, 32'd0);
    end
    step();
    bus.rsp0_ready = 1;
    acc = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.req1_ready) begin
        acc = ecount + 1;
        step();
        bus.req1_valid = 0;
        break;
      end
    end
    check("bp_release_grant", {31'd0, acc > 0}, 32'd1);
    wait_rsp(1'b1, acc, lat);
    check("bp_p1_data", {24'd0, bus.rsp_data}, 32'h03);

    // one requester streaming alone is served every time
    step();
    bus.req0_valid = 1; bus.req0_op = 3'd2;
    bus.req0_a = 8'h03; bus.req0_b = 8'h04;
    cnt = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (bus.req0_ready) cnt++;
      step();
    end
    bus.req0_valid = 0;
    check("stream_grants", cnt, 32'd3);

    // reset in the middle of a multiply
    step();
    step();
    issue(1'b1, 3'd7, 8'h03, 8'h05, acc);
    rst = 0;
    step();
    rst = 1;
    @(negedge clk);
    check("mid_busy", {31'd0, bus.busy}, 32'd0);
    check("mid_rv0", {31'd0, bus.rsp0_valid}, 32'd0);
    check("mid_rv1", {31'd0, bus.rsp1_valid}, 32'd0);
    check("mid_data", {24'd0, bus.rsp_data}, 32'd0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.rsp0_valid || bus.rsp1_valid) cnt++;
    end
    check("mid_no_rsp", cnt, 32'd0);

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
